// File: rtl/float_div_if.sv
// Operand/result handshake bundle for the single-precision divider.
// The master drives operands and the result ready; the slave returns ready, valid and quotient.
interface float_div_if #(
   parameter int Width = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [Width-1:0] a;
   logic [Width-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [Width-1:0] c;

   modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, c);
   modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, c);
endinterface

// File: rtl/float_div.sv
// Multi-cycle IEEE 754 single-precision divider, c = a / b, truncating.
// Restoring radix-2 mantissa division, one quotient bit per clock, one operation in flight.
module float_div #(
   parameter int E     = 8,
   parameter int M     = 23,
   parameter int Width = 1 + E + M
) (
   input  logic        clk,
   input  logic        rst_n,
   float_div_if.slave  bus
);
   localparam int ITER = M + 2;
   localparam int CW   = $clog2(ITER);
   localparam logic [CW-1:0]         CNT_LAST = CW'(ITER - 1);
   localparam logic signed [E+1:0]   BIAS_V   = (E+2)'((1 << (E - 1)) - 1);
   localparam logic signed [E+1:0]   EXP_ONE  = (E+2)'(1);
   localparam logic signed [E+1:0]   EXP_ZERO = (E+2)'(0);
   localparam logic signed [E+1:0]   EXP_MAX  = {2'b00, {E{1'b1}}};
   localparam logic [Width-1:0]      QNAN     = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

   state_t           state_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [Width-1:0] c_r;
   logic             sign_r;
   logic [E-1:0]     ea_r;
   logic [E-1:0]     eb_r;
   logic [M:0]       mb_r;
   logic [M+1:0]     rem_r;
   logic [M+1:0]     q_r;
   logic [CW-1:0]    cnt_r;
   logic             spec_r;
   logic [Width-1:0] spec_val_r;

   logic [E-1:0]     a_exp_s;
   logic [E-1:0]     b_exp_s;
   logic             sign_in_s;
   logic             spec_s;
   logic [Width-1:0] spec_val_s;
   logic             ge_s;
   logic [M+1:0]     rem_sub_s;
   logic [M+1:0]     rem_next_s;
   logic signed [E+1:0] e_s;
   logic signed [E+1:0] exp_s;
   logic [M-1:0]     mant_s;
   logic [Width-1:0] norm_val_s;

   assign a_exp_s   = bus.a[Width-2:M];
   assign b_exp_s   = bus.b[Width-2:M];
   assign sign_in_s = bus.a[Width-1] ^ bus.b[Width-1];

   // Special-operand detection; a zero exponent flushes denormals to zero.
   always_comb begin
      spec_s     = 1'b1;
      spec_val_s = '0;
      if ((&a_exp_s) || (&b_exp_s)) begin
         spec_val_s = QNAN;
      end else if ((a_exp_s == '0) && (b_exp_s == '0)) begin
         spec_val_s = QNAN;
      end else if (b_exp_s == '0) begin
         spec_val_s = {sign_in_s, {E{1'b1}}, {M{1'b0}}};
      end else if (a_exp_s == '0) begin
         spec_val_s = {sign_in_s, {(Width-1){1'b0}}};
      end else begin
         spec_s     = 1'b0;
         spec_val_s = '0;
      end
   end

   // One restoring step: the remainder stays below 2*mb so the shift never loses a set bit.
   always_comb begin
      ge_s       = (rem_r >= {1'b0, mb_r});
      rem_sub_s  = ge_s ? (rem_r - {1'b0, mb_r}) : rem_r;
      rem_next_s = {rem_sub_s[M:0], 1'b0};
   end

   assign e_s = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + BIAS_V;

   // Normalise the 25-bit quotient, truncate, saturate to inf or flush to zero.
   always_comb begin
      mant_s = q_r[M+1] ? q_r[M:1] : q_r[M-1:0];
      exp_s  = q_r[M+1] ? e_s : (e_s - EXP_ONE);
      if (exp_s >= EXP_MAX) begin
         norm_val_s = {sign_r, {E{1'b1}}, {M{1'b0}}};
      end else if (exp_s <= EXP_ZERO) begin
         norm_val_s = {sign_r, {(Width-1){1'b0}}};
      end else begin
         norm_val_s = {sign_r, exp_s[E-1:0], mant_s};
      end
   end

   // Control FSM with datapath registers and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         c_r         <= '0;
         sign_r      <= 1'b0;
         ea_r        <= '0;
         eb_r        <= '0;
         mb_r        <= '0;
         rem_r       <= '0;
         q_r         <= '0;
         cnt_r       <= '0;
         spec_r      <= 1'b0;
         spec_val_r  <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  in_ready_r <= 1'b0;
                  sign_r     <= sign_in_s;
                  ea_r       <= a_exp_s;
                  eb_r       <= b_exp_s;
                  mb_r       <= {1'b1, bus.b[M-1:0]};
                  rem_r      <= {2'b01, bus.a[M-1:0]};
                  q_r        <= '0;
                  cnt_r      <= '0;
                  spec_r     <= spec_s;
                  spec_val_r <= spec_val_s;
                  state_r    <= spec_s ? NORM : DIV;
               end
            end
            DIV: begin
               rem_r <= rem_next_s;
               q_r   <= {q_r[M:0], ge_s};
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == CNT_LAST) begin
                  state_r <= NORM;
               end
            end
            NORM: begin
               c_r         <= spec_r ? spec_val_r : norm_val_s;
               out_valid_r <= 1'b1;
               state_r     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.c         = c_r;
endmodule

// File: tb/tb_float_div.sv
// Self-checking bench for float_div: directed cases plus random operands
// compared against an integer-arithmetic reference of the truncating division rules.
module tb_float_div;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   float_div_if #(.Width(32)) bus ();

   float_div dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: classify specials, else q = floor(ma*2^24/mb) and normalise.
   function automatic void ref_div(input logic [31:0] av, input logic [31:0] bv,
                                   output logic [31:0] cv, output int lat);
      int     ea;
      int     eb;
      int     e;
      logic   s;
      longint ma;
      longint mb;
      longint q;
      longint mant;
      logic [31:0] ebits;
      ea = int'(av[30:23]);
      eb = int'(bv[30:23]);
      s  = av[31] ^ bv[31];
      lat = 1;
      if (ea == 255 || eb == 255)      cv = 32'h7FC00000;
      else if (ea == 0 && eb == 0)     cv = 32'h7FC00000;
      else if (eb == 0)                cv = {s, 8'hFF, 23'h0};
      else if (ea == 0)                cv = {s, 31'h0};
      else begin
         lat  = 26;
         ma   = 64'd8388608 + longint'(av[22:0]);
         mb   = 64'd8388608 + longint'(bv[22:0]);
         q    = (ma * 64'd16777216) / mb;
         e    = ea - eb + 127;
         if (q >= 64'd16777216) mant = (q / 64'd2) % 64'd8388608;
         else begin
            mant = q % 64'd8388608;
            e    = e - 1;
         end
         ebits = 32'(e);
         if (e >= 255)    cv = {s, 8'hFF, 23'h0};
         else if (e <= 0) cv = {s, 31'h0};
         else             cv = {s, ebits[7:0], mant[22:0]};
      end
   endfunction

   // Full transaction: accept, wait bounded for out_valid, check, optional hold, handshake.
   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_c, input int exp_lat,
                         input bit backp, input bit pulse);
      int n;
      @(negedge clk);
      check_int({tag, "_in_ready_idle"}, int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.a = av;
      bus.b = bv;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
      check_int({tag, "_busy"}, int'(bus.in_ready), 0);
      n = 0;
      while (!bus.out_valid && n < 60) begin
         @(posedge clk);
         #1;
         n++;
         if (pulse) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a = $urandom;
            bus.b = $urandom;
         end
      end
      bus.in_valid = 1'b0;
      check_int({tag, "_valid"}, int'(bus.out_valid), 1);
      check_int({tag, "_latency"}, n, exp_lat);
      check32({tag, "_c"}, bus.c, exp_c);
      if (backp) begin
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check32({tag, "_hold"}, {bus.c[31:2], bus.out_valid, bus.in_ready}, {exp_c[31:2], 1'b1, 1'b0});
         end
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check_int({tag, "_released"}, int'({bus.out_valid, bus.in_ready}), 1);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] rc;
      int          rl;
      total = 0;
      bad   = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = 32'h0;
      bus.b = 32'h0;
      rst_n = 1'b0;
      #12;
      check_int("reset_in_ready", int'(bus.in_ready), 1);
      check_int("reset_out_valid", int'(bus.out_valid), 0);
      check32("reset_c", bus.c, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 26, 1'b0, 1'b0);
      run_op("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26, 1'b0, 1'b0);
      run_op("neg_four_by_two", 32'hC0800000, 32'h40000000, 32'hC0000000, 26, 1'b0, 1'b0);
      run_op("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1, 1'b0, 1'b0);
      run_op("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 1, 1'b0, 1'b0);
      run_op("zero_by_two", 32'h00000000, 32'h40000000, 32'h00000000, 1, 1'b0, 1'b0);
      run_op("inf_by_one", 32'h7F800000, 32'h3F800000, 32'h7FC00000, 1, 1'b0, 1'b0);
      run_op("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 26, 1'b0, 1'b0);
      run_op("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 26, 1'b0, 1'b0);
      run_op("backpressure", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26, 1'b1, 1'b1);
      run_op("back_to_back", 32'hC0800000, 32'h40000000, 32'hC0000000, 26, 1'b0, 1'b0);

      // Abort at iteration 10 with an asynchronous reset pulse.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = 32'h40C00000;
      bus.b = 32'h40000000;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_int("abort_in_ready", int'(bus.in_ready), 1);
      check_int("abort_out_valid", int'(bus.out_valid), 0);
      check32("abort_c", bus.c, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check_int("abort_no_output", int'(bus.out_valid), 0);
      run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 26, 1'b0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         ra = $urandom;
         rb = $urandom;
         if (k % 8 == 3) rb[30:23] = 8'h00;
         if (k % 8 == 5) ra[30:23] = 8'hFF;
         if (k % 4 == 1) ra[30:23] = 8'(rb[30:23] + 8'($urandom_range(0, 3)));
         ref_div(ra, rb, rc, rl);
         run_op("random", ra, rb, rc, rl, 1'b0, k % 5 == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
